// File: rtl/data_mem_responder_if.sv
// Load/store bus between the MIPS datapath (master) and the data-memory
// responder (slave). The byte-enable lane mask exists only when
// DMEM_BYTE_EN_EN is defined.
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  memread;
  logic                  memwrite;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  stall;
  logic                  err;
`ifdef DMEM_BYTE_EN_EN
  logic [DATA_WIDTH/8-1:0] be;

  modport master (
    output memread, memwrite, addr, writedata, be,
    input  readdata, stall, err
  );

  modport slave (
    input  memread, memwrite, addr, writedata, be,
    output readdata, stall, err
  );
`else
  modport master (
    output memread, memwrite, addr, writedata,
    input  readdata, stall, err
  );

  modport slave (
    input  memread, memwrite, addr, writedata,
    output readdata, stall, err
  );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle MIPS core. Adds LATENCY wait
// states to every legal load/store and holds the core with stall until the
// access completes. Optional byte-lane writes: define DMEM_BYTE_EN_EN.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | accepting requests; stall follows a legal request directly
// WAIT  | counting wait states; RAM commit on the cnt==1 edge
// RESP  | access done, stall low so the core advances; back to IDLE
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BEW   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  req;
  logic                  both;
  logic                  misalign;
  logic                  accept;
  logic                  last_wait;
  logic                  imm;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [DATA_WIDTH-1:0] c_data;

  // Address bits above the word index are ignored so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];

  assign req    = bus.memread | bus.memwrite;
  assign both   = bus.memread & bus.memwrite;
  assign in_idx = bus.addr[ADDR_WIDTH+1:2];

`ifdef DMEM_BYTE_EN_EN
  localparam logic [BEW-1:0] BE_LO = BEW'(3);
  localparam logic [BEW-1:0] BE_HI = BE_LO << (BEW - 2);

  logic [BEW-1:0] be_q;
  logic [BEW-1:0] c_be;

  // Writes only fault on an odd-addressed halfword; reads keep word alignment.
  always_comb begin
    if (bus.memwrite)
      misalign = ((bus.be == BE_LO) || (bus.be == BE_HI)) && bus.addr[0];
    else
      misalign = (bus.addr[1:0] != 2'b00);
  end
`else
  assign misalign = (bus.addr[1:0] != 2'b00);
`endif

  assign accept    = (state == IDLE) && req && !misalign;
  assign last_wait = (state == WAIT) && (cnt == 4'd1);
  // With no wait states the commit happens straight out of IDLE.
  assign imm       = accept && (LATENCY == 0);
  assign wr_en     = (last_wait && wr_q)  || (imm && bus.memwrite);
  assign rd_en     = (last_wait && !wr_q) || (imm && !bus.memwrite);
  assign c_idx     = last_wait ? idx_q   : in_idx;
  assign c_data    = last_wait ? wdata_q : bus.writedata;
`ifdef DMEM_BYTE_EN_EN
  assign c_be      = last_wait ? be_q    : bus.be;
`endif

  assign bus.stall    = accept || (state == WAIT);
  assign bus.err      = (state == IDLE) && req && (misalign || both);
  assign bus.readdata = readdata_q;

  // RAM array: no reset, contents survive reset; commits only from the FSM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef DMEM_BYTE_EN_EN
      for (int i = 0; i < BEW; i++)
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
`else
      mem[c_idx] <= c_data;
`endif
    end
  end

  // Access sequencer: latches the request, counts wait states, loads readdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      readdata_q <= '0;
`ifdef DMEM_BYTE_EN_EN
      be_q       <= '0;
`endif
    end else begin
      if (rd_en) readdata_q <= mem[c_idx];
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q   <= in_idx;
            wdata_q <= bus.writedata;
            wr_q    <= bus.memwrite;
`ifdef DMEM_BYTE_EN_EN
            be_q    <= bus.be;
`endif
            cnt     <= 4'(LATENCY);
            state   <= (LATENCY > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with none. Byte-lane checks are compiled only with DMEM_BYTE_EN_EN.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [3:0] be_val = 4'hF;

  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_WIDTH(32)) ifa ();
  data_mem_responder_if #(.DATA_WIDTH(32)) ifb ();

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      ifa.memread = rd; ifa.memwrite = wr; ifa.addr = a; ifa.writedata = d;
`ifdef DMEM_BYTE_EN_EN
      ifa.be = be_val;
`endif
    end else begin
      ifb.memread = rd; ifb.memwrite = wr; ifb.addr = a; ifb.writedata = d;
`ifdef DMEM_BYTE_EN_EN
      ifb.be = be_val;
`endif
    end
  endtask

  function automatic logic get_stall(input int sel);
    return (sel == 0) ? ifa.stall : ifb.stall;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? ifa.err : ifb.err;
  endfunction

  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 0) ? ifa.readdata : ifb.readdata;
  endfunction

  // Issue one request, hold it while stalled, drop it after the response cycle.
  task automatic access(input int sel, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit exp_err, input int exp_stall, input string tag);
    int n = 0;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, d);
    @(negedge clk);
    check({tag, "_err"}, 32'(get_err(sel)), 32'(exp_err));
    while (get_stall(sel) && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'h0, get_err(sel), get_stall(sel)}, 32'h0);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rd_a", ifa.readdata, 32'h0);
    check("reset_rd_b", ifb.readdata, 32'h0);
    check("reset_stall_err_a", {30'h0, ifa.err, ifa.stall}, 32'h0);
    check("reset_stall_err_b", {30'h0, ifb.err, ifb.stall}, 32'h0);

    // Basic write then read with two wait states.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 3, "wr_10");
    check("rd_hold_after_wr", get_rd(0), 32'h0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 3, "rd_10");
    check("rd_10_data", get_rd(0), 32'hDEADBEEF);

    // Neighbouring word, then wrapped alias of 0x10.
    access(0, 1'b0, 1'b1, 32'h14, 32'h11111111, 1'b0, 3, "wr_14");
    access(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 3, "rd_14");
    check("rd_14_data", get_rd(0), 32'h11111111);
    access(0, 1'b1, 1'b0, 32'h410, 32'h0, 1'b0, 3, "rd_410");
    check("rd_410_wrap", get_rd(0), 32'hDEADBEEF);

    // Misaligned read: one-cycle err, no stall, readdata untouched.
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 0, "rd_13_misalign");
    check("rd_13_unchanged", get_rd(0), 32'hDEADBEEF);

    // Reset during WAIT drops the pending write.
    access(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 3, "wr_20");
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    check("abort_req_stall", 32'(ifa.stall), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("abort_stall_drop", 32'(ifa.stall), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_rd_reset", ifa.readdata, 32'h0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 3, "rd_20");
    check("rd_20_old_value", get_rd(0), 32'hCAFEF00D);

    // Read and write together: err pulses but the write goes through.
    access(0, 1'b1, 1'b1, 32'h30, 32'h00000055, 1'b1, 3, "both_30");
    check("both_rd_hold", get_rd(0), 32'hCAFEF00D);
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 3, "rd_30");
    check("rd_30_data", get_rd(0), 32'h00000055);

    // Zero wait states.
    access(1, 1'b0, 1'b1, 32'h0, 32'h00000001, 1'b0, 1, "l0_wr_0");
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1, "l0_rd_0");
    check("l0_rd_0_data", get_rd(1), 32'h00000001);

`ifdef DMEM_BYTE_EN_EN
    access(1, 1'b0, 1'b1, 32'h0, 32'hAABBCCDD, 1'b0, 1, "be_init");
    be_val = 4'b0010;
    access(1, 1'b0, 1'b1, 32'h0, 32'h11223344, 1'b0, 1, "be_lane1");
    be_val = 4'hF;
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1, "be_rd");
    check("be_merge_data", get_rd(1), 32'hAABB33DD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the far side of the single-cycle MIPS datapath's load/store interface.
- Takes `aluout` as the address, plus `writedata` and the `memread`/`memwrite` controls, from the core. Returns `readdata`.
- Inserts a programmable number of wait states and holds the core with `stall` until the access completes.
- Sits between the datapath and the word-addressed data RAM inside the top-level MIPS wrapper.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 8, word-index width. Depth is 2**ADDR_WIDTH words.
- LATENCY, 2, wait cycles per access. Legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- memread  in  1  load request from the core.
- memwrite  in  1  store request from the core.
- addr  in  32  byte address (core `aluout`).
- writedata  in  DATA_WIDTH  store data.
- readdata  out  DATA_WIDTH  load data, registered.
- stall  out  1  core must hold PC and pipeline state while high.
- err  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset values: FSM=IDLE, readdata=0, stall=0, err=0, wait counter=0.
  - Reset does not clear RAM contents.
  - Reset asserted mid-access aborts the access. A pending write is dropped and RAM is left unchanged.
- Request: req = memread | memwrite.
- Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the depth.
- Illegal request: req with addr[1:0] != 0.
  - err=1 for that cycle, stall=0, no access, FSM stays IDLE.
- Both memread and memwrite high: treated as a write, and err pulses for that cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - stall = legal req (combinational).
  - On a legal req: latch index, writedata and op; load cnt=LATENCY.
  - Next state: WAIT if LATENCY>0, else RESP.
- WAIT:
  - stall=1. cnt decrements each cycle.
  - When cnt==1: go to RESP. On that edge, a write commits to RAM, or a read loads readdata from RAM[index].
  - With LATENCY=0, the commit/load happens on the IDLE->RESP edge instead.
- RESP:
  - stall=0, so the core advances on this edge.
  - No request is accepted in RESP. Always returns to IDLE.
- Total access time: a request seen in cycle N completes with stall low in cycle N+LATENCY+1.
- The address, data and op are latched in IDLE, so input changes during WAIT are ignored.
- readdata holds its last load value across writes and idle cycles. It changes only on a read commit.
- A read immediately after a write to the same index returns the new data.
- Back-to-back requests incur the IDLE re-entry cycle; there is no overlap.

Optional Feature:
- Macro: DMEM_BYTE_EN_EN.
- When defined:
  - Adds input port `be`, width DATA_WIDTH/8, latched alongside the other request fields in IDLE.
  - On a write, only byte lanes with be[i]=1 are updated. be=0 on a write is a legal no-op.
  - Misalignment check is relaxed: it applies only when be selects a halfword (be=0011 or 1100) that is not halfword-aligned.
  - Reads ignore be.
- When undefined: no `be` port; every write updates the full word.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10, LATENCY=2 -> stall high for 3 cycles, low in the 4th; RAM[4]=0xDEADBEEF; err=0.
- Read addr 0x10 -> stall 3 cycles, then readdata=0xDEADBEEF; a following read of addr 0x410 (ADDR_WIDTH=8) also returns 0xDEADBEEF (wrap).
- Read addr 0x13 -> err pulses one cycle, stall=0, readdata unchanged.
- Assert reset during WAIT of a write of 0x12345678 to 0x20 -> stall drops immediately; a later read of 0x20 returns the previous value.
- LATENCY=0: write 0x1 to 0x0 then read 0x0 -> stall high exactly 1 cycle each; readdata=0x00000001.
- DMEM_BYTE_EN_EN: RAM[0]=0xAABBCCDD, write 0x11223344 with be=0010 -> RAM[0]=0xAABB33DD.
